// File: rtl/bbp_update_queue_if.sv
// Handshake bundle between fetch/execute and the branch update queue,
// plus the queue's write port towards the bimodal predictor table.
interface bbp_update_queue_if #(
  parameter int TAG_W = 3,
  parameter int IDX_W = 10
);
  logic             alloc_valid;
  logic [IDX_W-1:0] alloc_index;
  logic             alloc_pred;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic             res_taken;
  logic             bbp_write;
  logic [IDX_W-1:0] bbp_write_address;
  logic             bbp_write_data;
  logic             mispredict;
  logic [TAG_W-1:0] mispredict_tag;
  logic [TAG_W:0]   count;

  modport master (
    output alloc_valid, alloc_index, alloc_pred, res_valid, res_tag, res_taken,
    input  alloc_ready, alloc_tag, bbp_write, bbp_write_address, bbp_write_data,
           mispredict, mispredict_tag, count
  );

  modport slave (
    input  alloc_valid, alloc_index, alloc_pred, res_valid, res_tag, res_taken,
    output alloc_ready, alloc_tag, bbp_write, bbp_write_address, bbp_write_data,
           mispredict, mispredict_tag, count
  );
endinterface

// File: rtl/bbp_update_queue.sv
// In-order retirement queue for bimodal predictor updates: buffers
// out-of-order resolutions and squashes younger entries on a mispredict.
module bbp_update_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3,
  parameter int IDX_W = 10
) (
  input  logic CLK,
  input  logic RESET,
  bbp_update_queue_if.slave bus
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] resolved_q, resolved_d;
  logic [DEPTH-1:0] pred_q, pred_d;
  logic [DEPTH-1:0] taken_q, taken_d;
  logic [IDX_W-1:0] index_q [DEPTH];
  logic [IDX_W-1:0] index_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             bbp_write_q, bbp_write_d;
  logic [IDX_W-1:0] bbp_write_address_q, bbp_write_address_d;
  logic             bbp_write_data_q, bbp_write_data_d;
  logic             mispredict_q, mispredict_d;
  logic [TAG_W-1:0] mispredict_tag_q, mispredict_tag_d;

  logic             full;
  logic             res_ok;
  logic             mispred;
  logic             retire;
  logic             alloc_acc;
  logic [TAG_W-1:0] res_off;
  logic [DEPTH-1:0] younger;

  assign full      = (count_q == (TAG_W+1)'(DEPTH));
  assign res_ok    = bus.res_valid && valid_q[bus.res_tag] && !resolved_q[bus.res_tag];
  assign mispred   = res_ok && (bus.res_taken != pred_q[bus.res_tag]);
  assign retire    = valid_q[head_q] && resolved_q[head_q];
  // A mispredict redirects fetch, so a same-cycle allocation is dropped.
  assign alloc_acc = bus.alloc_valid && !full && !mispred;
  assign res_off   = bus.res_tag - head_q;

  // Age of each slot relative to head; slots older than the resolving
  // branch (or the branch itself) survive a squash.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [TAG_W-1:0] age;
    assign age         = TAG_W'(gi) - head_q;
    assign younger[gi] = (age > res_off);
  end

  always_comb begin
    valid_d             = valid_q;
    resolved_d          = resolved_q;
    pred_d              = pred_q;
    taken_d             = taken_q;
    index_d             = index_q;
    head_d              = head_q;
    tail_d              = tail_q;
    count_d             = count_q;
    bbp_write_d         = 1'b0;
    bbp_write_address_d = bbp_write_address_q;
    bbp_write_data_d    = bbp_write_data_q;
    mispredict_d        = 1'b0;
    mispredict_tag_d    = mispredict_tag_q;

    if (retire) begin
      valid_d[head_q]     = 1'b0;
      resolved_d[head_q]  = 1'b0;
      head_d              = head_q + TAG_W'(1);
      bbp_write_d         = 1'b1;
      bbp_write_address_d = index_q[head_q];
      bbp_write_data_d    = taken_q[head_q];
    end

    if (res_ok) begin
      resolved_d[bus.res_tag] = 1'b1;
      taken_d[bus.res_tag]    = bus.res_taken;
    end

    if (mispred) begin
      mispredict_d     = 1'b1;
      mispredict_tag_d = bus.res_tag;
      valid_d          = valid_d & ~younger;
      resolved_d       = resolved_d & ~younger;
      tail_d           = bus.res_tag + TAG_W'(1);
      count_d          = (TAG_W+1)'(res_off) + (TAG_W+1)'(1) - (TAG_W+1)'(retire);
    end else begin
      if (alloc_acc) begin
        valid_d[tail_q]    = 1'b1;
        resolved_d[tail_q] = 1'b0;
        pred_d[tail_q]     = bus.alloc_pred;
        index_d[tail_q]    = bus.alloc_index;
        tail_d             = tail_q + TAG_W'(1);
      end
      count_d = count_q + (TAG_W+1)'(alloc_acc) - (TAG_W+1)'(retire);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q             <= '0;
      resolved_q          <= '0;
      pred_q              <= '0;
      taken_q             <= '0;
      for (int i = 0; i < DEPTH; i++) index_q[i] <= '0;
      head_q              <= '0;
      tail_q              <= '0;
      count_q             <= '0;
      bbp_write_q         <= 1'b0;
      bbp_write_address_q <= '0;
      bbp_write_data_q    <= 1'b0;
      mispredict_q        <= 1'b0;
      mispredict_tag_q    <= '0;
    end else begin
      valid_q             <= valid_d;
      resolved_q          <= resolved_d;
      pred_q              <= pred_d;
      taken_q             <= taken_d;
      index_q             <= index_d;
      head_q              <= head_d;
      tail_q              <= tail_d;
      count_q             <= count_d;
      bbp_write_q         <= bbp_write_d;
      bbp_write_address_q <= bbp_write_address_d;
      bbp_write_data_q    <= bbp_write_data_d;
      mispredict_q        <= mispredict_d;
      mispredict_tag_q    <= mispredict_tag_d;
    end
  end

  assign bus.alloc_ready       = !full;
  assign bus.alloc_tag         = tail_q;
  assign bus.count             = count_q;
  assign bus.bbp_write         = bbp_write_q;
  assign bus.bbp_write_address = bbp_write_address_q;
  assign bus.bbp_write_data    = bbp_write_data_q;
  assign bus.mispredict        = mispredict_q;
  assign bus.mispredict_tag    = mispredict_tag_q;

endmodule

// File: doc/bbp_update_queue.md
# bbp_update_queue

Tracks every branch predicted by the bimodal predictor from fetch until it resolves in execute. It then writes the actual outcome back into the predictor's 2-bit counter table in program order, one update per cycle. It sits between the predictor (downstream, via its write port) and the fetch/execute stages (upstream, which allocate and resolve entries). Out-of-order resolutions are buffered, and a misprediction squashes all younger in-flight entries.

## Interface
- DEPTH, 8, queue entries; power of two, at least 2
- TAG_W, 3, tag width; equals log2(DEPTH)
- IDX_W, 10, predictor table index width
- CLK  in  1  clock, rising edge
- RESET  in  1  reset, asynchronous, active-low
- alloc_valid  in  1  fetch requests an entry this cycle
- alloc_index  in  IDX_W  predictor index of the branch
- alloc_pred  in  1  predicted direction (MSB of predictor counter)
- alloc_ready  out  1  queue not full; combinational from count
- alloc_tag  out  TAG_W  tag given to an allocation this cycle (= tail pointer)
- res_valid  in  1  execute resolves a branch
- res_tag  in  TAG_W  tag being resolved
- res_taken  in  1  actual direction
- bbp_write  out  1  registered one-cycle write strobe to predictor
- bbp_write_address  out  IDX_W  index to update
- bbp_write_data  out  1  actual outcome (1 = taken)
- mispredict  out  1  registered one-cycle pulse; resolved outcome differed from prediction
- mispredict_tag  out  TAG_W  tag of the mispredicted branch
- count  out  TAG_W+1  occupied entries

## Operation
- Each entry holds: valid, resolved, index, pred, taken.
- Pointers: head (oldest) and tail (next free), both TAG_W bits, wrapping modulo DEPTH.
- Alloc: accepted when alloc_valid && alloc_ready. The entry at tail is written with valid=1 and resolved=0, then tail increments.
- Alloc while full: ignored, with no state change.
- Resolve: accepted only when entry[res_tag] is valid and not yet resolved. It sets resolved=1 and taken=res_taken.
- Resolve to an invalid or already-resolved entry: ignored, with no pulse.
- Mispredict: an accepted resolve with res_taken != pred does three things in the same edge:
  - pulses mispredict with mispredict_tag=res_tag;
  - clears valid on every entry younger than res_tag (those at age offset from head greater than (res_tag - head) mod DEPTH);
  - sets tail = res_tag+1 mod DEPTH.
- The mispredicted entry itself stays in the queue and later retires, training the predictor.
- Retire: if the head entry has valid and resolved set at the start of the cycle, the edge:
  - clears it;
  - increments head;
  - registers bbp_write=1, bbp_write_address=index, bbp_write_data=taken.
- At most one retire per cycle.
- Count on a normal cycle: count_next = count + alloc_accepted - retire.
- Count on a mispredict cycle: count_next = ((res_tag - head) mod DEPTH) + 1 - retire.
- An alloc in the same cycle as a mispredicting resolve is discarded. Fetch is redirected anyway.
- Alloc and a non-mispredicting resolve in the same cycle are both performed.
- Alloc while full in the same cycle as a retire: still rejected, because alloc_ready is based on the registered count.
- Reset: all valid and resolved bits 0, head=tail=0, count=0.
  - Outputs after reset: bbp_write=0, bbp_write_address=0, bbp_write_data=0, mispredict=0, mispredict_tag=0.
  - alloc_ready=1, alloc_tag=0.
- Reset asserted mid-operation discards all entries immediately; no pending write is emitted.

## Timing
- Resolution at edge N (flag set) leads to retire at edge N+1 at the earliest, with bbp_write high during cycle N+1..N+2.
- Minimum latency from resolve to predictor write: 2 edges.
- mispredict is high for exactly one cycle after the resolving edge.
- bbp_write is high for exactly one cycle per retired entry.
- Back-to-back retires of resolved entries produce consecutive bbp_write cycles.
- alloc_ready and alloc_tag are valid combinationally from registered state in the same cycle.
- Tags are reused only after retirement. A tag is never assigned to two live entries.

## Test plan
- **Reset:** hold RESET low with random inputs. Required: all outputs 0, alloc_ready=1, count=0. After release, allocate index 0x155 with pred=1 → alloc_tag=0, then count=1.
- **In-order retire:** allocate tags 0,1,2 (indices 0x010, 0x020, 0x030; pred=1), then resolve all taken in order. Required: bbp_write pulses on consecutive cycles with addresses 0x010, 0x020, 0x030 and data 1; mispredict never asserts.
- **Out-of-order resolve:** with tags 0..3 allocated, resolve 3, 2, 1, 0. Required: no bbp_write until tag 0 resolves, then four consecutive writes in tag order 0..3.
- **Mispredict squash:** allocate tags 0..5, then resolve tag 2 with res_taken != pred. Required:
  - mispredict=1 with mispredict_tag=2;
  - count becomes 3 and the next alloc_tag=3;
  - later resolves of old tags 3..5 before reallocation are ignored;
  - tag 2 still retires with the actual outcome.
- **Full/wrap:** allocate 8 entries. Required: alloc_ready=0 and a 9th alloc is ignored. Retire 3, allocate 3 more. Required: tags issued are 0,1,2 (wrapped) and count=8.
- **Mid-operation reset:** assert RESET with 4 resolved entries pending. Required: no further bbp_write, count=0 immediately.
